// File: rtl/alu_interface_pkg.sv
// Shared types and constants for the UART-to-ALU bridge and the external ALU beside it.
`timescale 1ns/1ps
package alu_interface_pkg;

    // Transaction phases: three received bytes, one result-launch cycle, then wait for the UART
    typedef enum logic [2:0] {
        StWaitA  = 3'd0,
        StWaitB  = 3'd1,
        StWaitOp = 3'd2,
        StSend   = 3'd3,
        StWaitTx = 3'd4
    } state_e;

    // ALU operation codes (MIPS funct-style encoding)
    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;
    localparam logic [5:0] OpOr  = 6'b100101;
    localparam logic [5:0] OpXor = 6'b100110;
    localparam logic [5:0] OpSra = 6'b000011;
    localparam logic [5:0] OpSrl = 6'b000010;
    localparam logic [5:0] OpNor = 6'b100111;

endpackage

// File: rtl/alu_interface.sv
// Collects operand A, operand B and an opcode from a UART receiver, presents them to an
// external ALU, and hands the ALU result back to a UART transmitter.
`timescale 1ns/1ps
module alu_interface
    import alu_interface_pkg::*;
#(
    parameter int unsigned NBITS  = 8,
    parameter int unsigned COD_OP = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NBITS-1:0]  rx_data,
    input  logic              rx_done,
    input  logic [NBITS-1:0]  alu_result,
    input  logic              tx_done,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    output logic [NBITS-1:0]  tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [NBITS-1:0]  operando_a_q, operando_a_d;
    logic [NBITS-1:0]  operando_b_q, operando_b_d;
    logic [COD_OP-1:0] cod_operacion_q, cod_operacion_d;
    logic [NBITS-1:0]  tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              overrun_q, overrun_d;

    // Next-state and register-load decode
    always_comb begin
        state_d         = state_q;
        operando_a_d    = operando_a_q;
        operando_b_d    = operando_b_q;
        cod_operacion_d = cod_operacion_q;
        tx_data_d       = tx_data_q;
        tx_start_d      = 1'b0;
        overrun_d       = overrun_q;

        case (state_q)
            StWaitA: begin
                if (rx_done) begin
                    operando_a_d = rx_data;
                    state_d      = StWaitB;
                end
            end
            StWaitB: begin
                if (rx_done) begin
                    operando_b_d = rx_data;
                    state_d      = StWaitOp;
                end
            end
            StWaitOp: begin
                if (rx_done) begin
                    // Upper bits of the opcode byte are discarded
                    cod_operacion_d = rx_data[COD_OP-1:0];
                    state_d         = StSend;
                end
            end
            StSend: begin
                // Operands and opcode have been stable for a full cycle, so the ALU output is settled
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
                if (rx_done) overrun_d = 1'b1;
            end
            StWaitTx: begin
                // A byte arriving here has nowhere to go; it is dropped even if tx_done coincides
                if (rx_done) overrun_d = 1'b1;
                if (tx_done) state_d = StWaitA;
            end
            default: begin
                state_d = StWaitA;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StWaitA;
            operando_a_q    <= '0;
            operando_b_q    <= '0;
            cod_operacion_q <= '0;
            tx_data_q       <= '0;
            tx_start_q      <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            operando_a_q    <= operando_a_d;
            operando_b_q    <= operando_b_d;
            cod_operacion_q <= cod_operacion_d;
            tx_data_q       <= tx_data_d;
            tx_start_q      <= tx_start_d;
            overrun_q       <= overrun_d;
        end
    end

    // Output mapping; busy is a pure decode of the current state
    always_comb begin
        operando_A    = operando_a_q;
        operando_B    = operando_b_q;
        cod_operacion = cod_operacion_q;
        tx_data       = tx_data_q;
        tx_start      = tx_start_q;
        overrun       = overrun_q;
        busy          = (state_q != StWaitA);
    end

endmodule

// File: tb/tb_alu_interface.sv
// Bench for alu_interface: directed vector table, corner-case sequences and randomized
// transactions checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_alu_interface;
    import alu_interface_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] operando_A;
    logic [7:0] operando_B;
    logic [5:0] cod_operacion;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    alu_interface #(.NBITS(8), .COD_OP(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .alu_result    (alu_result),
        .tx_done       (tx_done),
        .operando_A    (operando_A),
        .operando_B    (operando_B),
        .cod_operacion (cod_operacion),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU wired beside the interface
    always_comb begin
        case (cod_operacion)
            OpAdd:   alu_result = operando_A + operando_B;
            OpSub:   alu_result = operando_A - operando_B;
            OpAnd:   alu_result = operando_A & operando_B;
            OpOr:    alu_result = operando_A | operando_B;
            OpXor:   alu_result = operando_A ^ operando_B;
            OpSra:   alu_result = $signed(operando_A) >>> operando_B;
            OpSrl:   alu_result = operando_A >> operando_B;
            OpNor:   alu_result = ~(operando_A | operando_B);
            default: alu_result = 8'hFF;
        endcase
    end

    // Reference result computed with integer arithmetic
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        int r;
        int sa;
        int sh;
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sh = (b >= 8'd8) ? 8 : int'(b);
        case (op)
            6'h20:   r = int'(a) + int'(b);
            6'h22:   r = int'(a) - int'(b);
            6'h24:   r = int'(a & b);
            6'h25:   r = int'(a | b);
            6'h26:   r = int'(a ^ b);
            6'h27:   r = 255 - int'(a | b);
            6'h02:   r = int'(a) / (1 << sh);
            6'h03:   r = sa >>> sh;
            default: r = 255;
        endcase
        return r[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    // Full transaction with timing checks on tx_start and busy
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] exp_tx, input logic [5:0] exp_cod, input string nm);
        send_byte(a);
        chk({nm, " busy after A"}, busy, 1);
        send_byte(b);
        send_byte(op);
        chk({nm, " no early start"}, tx_start, 0);
        chk({nm, " cod"}, cod_operacion, exp_cod);
        idle(1);
        chk({nm, " tx_start"}, tx_start, 1);
        chk({nm, " tx_data"}, tx_data, exp_tx);
        chk({nm, " opA"}, operando_A, a);
        chk({nm, " opB"}, operando_B, b);
        idle(1);
        chk({nm, " start one cycle"}, tx_start, 0);
        chk({nm, " busy in wait tx"}, busy, 1);
        pulse_tx();
        chk({nm, " idle after tx_done"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp_tx;
        logic [5:0] exp_cod;
    } vec_t;

    vec_t       vecs[10];
    logic [5:0] valid_ops[8];
    logic [7:0] ra, rb, rop, rexp;
    logic       exp_ovr;

    initial begin
        reset   = 1'b1;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, 6'h22};
        vecs[2] = '{8'hF0, 8'h0F, 8'h27, 8'h00, 6'h27};
        vecs[3] = '{8'h11, 8'h22, 8'h00, 8'hFF, 6'h00};
        vecs[4] = '{8'h80, 8'h02, 8'hC3, 8'hE0, 6'h03};
        vecs[5] = '{8'hF0, 8'h3C, 8'h24, 8'h30, 6'h24};
        vecs[6] = '{8'h0A, 8'h50, 8'h25, 8'h5A, 6'h25};
        vecs[7] = '{8'hFF, 8'h0F, 8'h26, 8'hF0, 6'h26};
        vecs[8] = '{8'h80, 8'h02, 8'h02, 8'h20, 6'h02};
        vecs[9] = '{8'hFF, 8'h02, 8'h60, 8'h01, 6'h20};

        valid_ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

        // Reset state
        idle(2);
        reset = 1'b0;
        chk("reset opA", operando_A, 0);
        chk("reset opB", operando_B, 0);
        chk("reset cod", cod_operacion, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset tx_start", tx_start, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_tx, vecs[i].exp_cod,
                   $sformatf("vec%0d", i));
        end
        chk("no overrun after clean txns", overrun, 0);

        // tx_done outside WAIT_TX is ignored
        send_byte(8'h09);
        pulse_tx();
        chk("tx_done ignored in WAIT_B", busy, 1);
        send_byte(8'h04);
        pulse_tx();
        send_byte(8'h22);
        idle(1);
        chk("tx_done ignored result", tx_data, 8'h05);
        idle(1);
        pulse_tx();
        chk("overrun untouched by tx_done", overrun, 0);

        // Byte arriving in WAIT_TX is dropped and flags overrun
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        idle(2);
        send_byte(8'h55);
        chk("overrun set in WAIT_TX", overrun, 1);
        chk("dropped byte not in opA", operando_A, 8'h07);
        chk("still busy after drop", busy, 1);
        pulse_tx();
        do_txn(8'h01, 8'h01, 8'h20, 8'h02, 6'h20, "after overrun");
        chk("overrun sticky", overrun, 1);

        // rx_done and tx_done together in WAIT_TX
        do_reset();
        chk("overrun cleared by reset", overrun, 0);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h20);
        idle(2);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        tx_done = 1'b1;
        idle(1);
        rx_done = 1'b0;
        tx_done = 1'b0;
        chk("coincident back to idle", busy, 0);
        chk("coincident overrun", overrun, 1);
        chk("coincident byte not captured", operando_A, 8'h03);

        // Reset mid-transaction discards the partial operand
        do_reset();
        send_byte(8'h7F);
        idle(1);
        do_reset();
        chk("midreset opA", operando_A, 0);
        chk("midreset busy", busy, 0);
        chk("midreset tx_data", tx_data, 0);
        chk("midreset overrun", overrun, 0);
        do_txn(8'h02, 8'h04, 8'h25, 8'h06, 6'h05 ^ 6'h20, "post reset");

        // Randomized transactions against the reference model
        do_reset();
        exp_ovr = 1'b0;
        for (int t = 0; t < 60; t++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            rop = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                              : {2'($urandom), valid_ops[$urandom_range(0, 7)]};
            rexp = ref_alu(ra, rb, rop[5:0]);

            send_byte(ra);
            repeat ($urandom_range(0, 2)) begin
                tx_done = 1'($urandom);
                idle(1);
                tx_done = 1'b0;
            end
            send_byte(rb);
            repeat ($urandom_range(0, 2)) idle(1);
            send_byte(rop);

            if ($urandom_range(0, 5) == 0) begin
                send_byte(8'($urandom));
                exp_ovr = 1'b1;
            end else begin
                idle(1);
            end
            chk("rand tx_start", tx_start, 1);
            chk("rand tx_data", tx_data, rexp);
            chk("rand cod", cod_operacion, rop[5:0]);

            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 7) == 0) begin
                    send_byte(8'($urandom));
                    exp_ovr = 1'b1;
                end else begin
                    idle(1);
                end
                chk("rand start low in WAIT_TX", tx_start, 0);
            end

            tx_done = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                rx_data = 8'($urandom);
                rx_done = 1'b1;
                exp_ovr = 1'b1;
            end
            idle(1);
            tx_done = 1'b0;
            rx_done = 1'b0;
            chk("rand idle", busy, 0);
            chk("rand overrun", overrun, exp_ovr);
            chk("rand opA held", operando_A, ra);
            chk("rand opB held", operando_B, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
